// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_slave
//  Description : APB completer with six RW control registers (0x0-0x5),
//                a RO write counter (0x6), a RO ID register (0x7) and an
//                error response for unmapped addresses (0x8-0xF).
//                Optional wait states delay pready in the access phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_slave #(
    parameter int         WAIT_STATES = 0,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [7:0]  pwdata,
    output logic [7:0]  prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [47:0] reg_q
);

    localparam logic [3:0] c_wait = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  r_addr;
    logic        r_write;
    logic [7:0]  r_wdata;
    logic [7:0]  r_prdata;
    logic [7:0]  r_wr_cnt;
    logic [7:0]  r_regs [6];
    logic [7:0]  w_rd_data;
    logic        w_setup;
    logic        w_pready;
    logic        w_complete;

    // A setup phase is only recognised from IDLE; psel+penable in IDLE is ignored
    assign w_setup    = (r_state == IDLE) && psel && !penable;
    assign w_pready   = (r_state == ACCESS) && (r_wait_cnt == c_wait);
    assign w_complete = w_pready && psel && penable;

    assign pready  = w_pready;
    assign pslverr = w_pready && r_addr[3];
    assign prdata  = r_prdata;

    // State register
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: setup enters ACCESS; completion or dropped psel returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || w_complete) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Read mux on the live address, sampled into prdata at the setup edge
    always_comb begin
        w_rd_data = 8'h00;
        case (paddr)
            4'h0, 4'h1, 4'h2,
            4'h3, 4'h4, 4'h5: w_rd_data = r_regs[paddr[2:0]];
            4'h6:             w_rd_data = r_wr_cnt;
            4'h7:             w_rd_data = ID_VALUE;
            default:          w_rd_data = 8'h00;
        endcase
    end

    // Capture transfer at setup, count wait cycles, commit writes on completion
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wait_cnt <= 4'd0;
            r_addr     <= 4'd0;
            r_write    <= 1'b0;
            r_wdata    <= 8'h00;
            r_prdata   <= 8'h00;
            r_wr_cnt   <= 8'h00;
            for (int i = 0; i < 6; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            if (w_setup) begin
                r_addr     <= paddr;
                r_write    <= pwrite;
                r_wdata    <= pwdata;
                r_wait_cnt <= 4'd0;
                r_prdata   <= pwrite ? 8'h00 : w_rd_data;
            end else if ((r_state == ACCESS) && !w_pready) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end

            // Only the six RW registers accept data; RO and unmapped writes are dropped
            if (w_complete && r_write && (r_addr < 4'd6)) begin
                r_regs[r_addr[2:0]] <= r_wdata;
                r_wr_cnt            <= r_wr_cnt + 8'd1;
            end
        end
    end

    generate
        for (genvar g = 0; g < 6; g++) begin : g_reg_q
            assign reg_q[g*8 +: 8] = r_regs[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_reg_slave
//  Description : Self-checking bench for apb_reg_slave. Two instances share
//                the bus wires (zero-wait and three-wait); each has its own
//                psel. Stimulus pushes expected responses into a queue that a
//                separate monitor pops on every completed transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_reg_slave;

    logic        pclk = 1'b0;
    logic        preset;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [7:0]  pwdata;
    logic        psel0, psel3;
    logic [7:0]  prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;
    logic [47:0] reg_q0, reg_q3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] dut;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    apb_reg_slave #(.WAIT_STATES(0), .ID_VALUE(8'hA5)) u_dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata0),
        .pready(pready0), .pslverr(pslverr0), .reg_q(reg_q0)
    );

    apb_reg_slave #(.WAIT_STATES(3), .ID_VALUE(8'hA5)) u_dut3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3),
        .pready(pready3), .pslverr(pslverr3), .reg_q(reg_q3)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic get_pready(input int d);
        return (d == 0) ? pready0 : pready3;
    endfunction

    task automatic set_psel(input int d, input logic v);
        if (d == 0) psel0 = v;
        else        psel3 = v;
    endtask

    // Monitor: every completed transfer pops one expected response
    task automatic mon_pop(input int d, input logic [7:0] rd, input logic err);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_completion", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("resp_dut",     d,   e.dut);
            check("resp_prdata",  rd,  e.rdata);
            check("resp_pslverr", err, e.err);
        end
    endtask

    initial begin
        forever begin
            @(negedge pclk);
            if (psel0 && penable && pready0) mon_pop(0, prdata0, pslverr0);
            if (psel3 && penable && pready3) mon_pop(3, prdata3, pslverr3);
        end
    end

    // Full transfer; bus lines are scrambled during access to prove capture at setup
    task automatic xfer(input int d, input logic wr, input logic [3:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input logic exp_err, input int exp_waits);
        int waits = 0;
        bit done  = 0;
        exp_t e;
        e.dut = 2'(d); e.rdata = exp_rd; e.err = exp_err;
        exp_q.push_back(e);
        pwrite = wr; paddr = a; pwdata = wd; penable = 1'b0;
        set_psel(d, 1'b1);
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr   = ~a;
        pwdata  = ~wd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge pclk);
            if (get_pready(d)) done = 1;
            else               waits++;
        end
        check("xfer_done", done, 1);
        check("xfer_waits", waits, exp_waits);
        @(posedge pclk); #1;
        set_psel(d, 1'b0);
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 4'h0; pwdata = 8'h00;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;

        // Reset state
        check("rst_pready0",  pready0,  0);
        check("rst_pslverr0", pslverr0, 0);
        check("rst_prdata0",  prdata0,  0);
        check("rst_reg_q0",   reg_q0,   0);
        check("rst_pready3",  pready3,  0);
        check("rst_reg_q3",   reg_q3,   0);

        // Zero-wait writes
        xfer(0, 1, 4'h1, 8'hAA, 8'h00, 0, 0);
        xfer(0, 1, 4'h2, 8'h55, 8'h00, 0, 0);
        xfer(0, 1, 4'h0, 8'h32, 8'h00, 0, 0);
        xfer(0, 1, 4'h4, 8'hBA, 8'h00, 0, 0);
        check("reg_q0_after_writes", reg_q0, 48'h00BA_0055_AA32);

        // RO/ID, readback, unmapped
        xfer(0, 1, 4'h7, 8'h10, 8'h00, 0, 0);
        xfer(0, 0, 4'h7, 8'h00, 8'hA5, 0, 0);
        xfer(0, 0, 4'h6, 8'h00, 8'h04, 0, 0);
        xfer(0, 0, 4'h1, 8'h00, 8'hAA, 0, 0);
        xfer(0, 0, 4'h0, 8'h00, 8'h32, 0, 0);
        xfer(0, 0, 4'h9, 8'h00, 8'h00, 1, 0);
        xfer(0, 1, 4'hC, 8'h77, 8'h00, 1, 0);
        check("reg_q0_after_unmapped", reg_q0, 48'h00BA_0055_AA32);
        xfer(0, 0, 4'h6, 8'h00, 8'h04, 0, 0);

        // Three wait states
        xfer(3, 1, 4'h2, 8'h55, 8'h00, 0, 3);
        xfer(3, 0, 4'h2, 8'h00, 8'h55, 0, 3);

        // Abort a waiting write by dropping psel
        pwrite = 1'b1; paddr = 4'h3; pwdata = 8'hEE; penable = 1'b0; psel3 = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        @(negedge pclk);
        check("abort_pready_low", pready3, 0);
        @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        check("abort_reg3", reg_q3[31:24], 8'h00);
        xfer(3, 0, 4'h6, 8'h00, 8'h01, 0, 3);

        // Reset during an access wait
        pwrite = 1'b1; paddr = 4'h4; pwdata = 8'h11; penable = 1'b0; psel3 = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        @(negedge pclk);
        @(posedge pclk); #1 preset = 1'b1; psel3 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1 preset = 1'b0;
        check("midrst_pready3", pready3, 0);
        check("midrst_reg_q3",  reg_q3,  0);
        check("midrst_reg_q0",  reg_q0,  0);
        xfer(3, 0, 4'h6, 8'h00, 8'h00, 0, 3);

        // Write counter wrap
        for (int i = 0; i < 256; i++) begin
            xfer(0, 1, 4'h5, 8'(i), 8'h00, 0, 0);
        end
        xfer(0, 0, 4'h6, 8'h00, 8'h00, 0, 0);
        xfer(0, 0, 4'h5, 8'h00, 8'hFF, 0, 0);
        check("wrap_reg5", reg_q0[47:40], 8'hFF);

        // Access strobe without setup is ignored
        pwrite = 1'b1; paddr = 4'h3; pwdata = 8'h99; psel0 = 1'b1; penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("noset_pready", pready0, 0);
        end
        @(posedge pclk); #1 psel0 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        check("noset_reg3", reg_q0[31:24], 8'h00);
        xfer(0, 1, 4'h3, 8'hC3, 8'h00, 0, 0);
        check("after_noset_reg3", reg_q0[31:24], 8'hC3);
        xfer(0, 0, 4'h6, 8'h00, 8'h01, 0, 0);

        repeat (2) @(posedge pclk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
